// File: rtl/vga_scene_render.sv
// Scene renderer for a 800x600 VGA stream: two-stage pixel pipeline that
// paints a screen border, one rectangular object and a background, with the
// object position updated only at frame boundaries to avoid tearing.
module vga_scene_render #(
  parameter int          OBJ_W        = 32,
  parameter int          OBJ_H        = 32,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] OBJ_COLOR    = 12'hF00,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        valid,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  input  logic        pos_wr,
  output logic        pos_busy,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic [15:0] frame_cnt
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t      state_reg, state_next;
  logic [10:0] act_x_reg, act_x_next, act_y_reg, act_y_next;
  logic [10:0] shadow_x_reg, shadow_x_next, shadow_y_reg, shadow_y_next;
  logic [15:0] frame_cnt_reg;

  // stage 1
  logic        valid_s1_reg, hsync_s1_reg, vsync_s1_reg, hit_s1_reg;
  logic [10:0] x_s1_reg, y_s1_reg;
  // stage 2
  logic        hsync_s2_reg, vsync_s2_reg;
  logic [11:0] rgb_reg, rgb_next;

  logic        boundary;
  logic        border_s1;
  logic [1:0]  axis_hit;
  logic [10:0] pix_pos   [2];
  logic [10:0] act_pos   [2];
  logic [10:0] req_pos   [2];
  logic [10:0] clamp_pos [2];

  assign pix_pos[0] = xpos;
  assign pix_pos[1] = ypos;
  assign act_pos[0] = act_x_reg;
  assign act_pos[1] = act_y_reg;
  assign req_pos[0] = pos_x;
  assign req_pos[1] = pos_y;

  // Per-axis object hit test and request clamp (axis 0 = x, axis 1 = y).
  // The end coordinate is formed 12 bits wide so a large position cannot wrap.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam logic [11:0] SIZE  = 12'((gi == 0) ? OBJ_W : OBJ_H);
      localparam logic [10:0] LIMIT = 11'((gi == 0) ? (800 - OBJ_W) : (600 - OBJ_H));
      logic [11:0] act_end;
      assign act_end       = {1'b0, act_pos[gi]} + SIZE;
      assign axis_hit[gi]  = (pix_pos[gi] >= act_pos[gi]) && ({1'b0, pix_pos[gi]} < act_end);
      assign clamp_pos[gi] = (req_pos[gi] > LIMIT) ? LIMIT : req_pos[gi];
    end
  endgenerate

  // The stage-1 vsync register doubles as the previous-vsync copy for edge detection.
  assign boundary = vsync_s1_reg & ~vsync_in;

  // Stage 1: capture pixel coordinates, syncs and the object hit.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      valid_s1_reg <= 1'b0;
      x_s1_reg     <= '0;
      y_s1_reg     <= '0;
      hsync_s1_reg <= 1'b1;
      vsync_s1_reg <= 1'b1;
      hit_s1_reg   <= 1'b0;
    end else begin
      valid_s1_reg <= valid;
      x_s1_reg     <= xpos;
      y_s1_reg     <= ypos;
      hsync_s1_reg <= hsync_in;
      vsync_s1_reg <= vsync_in;
      hit_s1_reg   <= &axis_hit;
    end
  end

  assign border_s1 = (x_s1_reg == 11'd0) || (x_s1_reg == 11'd799) ||
                     (y_s1_reg == 11'd0) || (y_s1_reg == 11'd599);

  // Colour selection: blanking, then border, then object, then background.
  always_comb begin
    rgb_next = BG_COLOR;
    if (!valid_s1_reg)   rgb_next = 12'h000;
    else if (border_s1)  rgb_next = BORDER_COLOR;
    else if (hit_s1_reg) rgb_next = OBJ_COLOR;
  end

  // Stage 2: registered colour and syncs, aligned with each other.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rgb_reg      <= 12'h000;
      hsync_s2_reg <= 1'b1;
      vsync_s2_reg <= 1'b1;
    end else begin
      rgb_reg      <= rgb_next;
      hsync_s2_reg <= hsync_s1_reg;
      vsync_s2_reg <= vsync_s1_reg;
    end
  end

  // Update FSM next state: capture a request when idle, commit it at the next boundary.
  always_comb begin
    state_next    = state_reg;
    act_x_next    = act_x_reg;
    act_y_next    = act_y_reg;
    shadow_x_next = shadow_x_reg;
    shadow_y_next = shadow_y_reg;
    case (state_reg)
      IDLE: begin
        if (pos_wr) begin
          shadow_x_next = clamp_pos[0];
          shadow_y_next = clamp_pos[1];
          state_next    = PENDING;
        end
      end
      PENDING: begin
        if (boundary) begin
          act_x_next = shadow_x_reg;
          act_y_next = shadow_y_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Update FSM state, position registers and frame counter.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      act_x_reg     <= '0;
      act_y_reg     <= '0;
      shadow_x_reg  <= '0;
      shadow_y_reg  <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      act_x_reg     <= act_x_next;
      act_y_reg     <= act_y_next;
      shadow_x_reg  <= shadow_x_next;
      shadow_y_reg  <= shadow_y_next;
      if (boundary) frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign pos_busy  = (state_reg == PENDING);
  assign hsync     = hsync_s2_reg;
  assign vsync     = vsync_s2_reg;
  assign rgb       = rgb_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_vga_scene_render.sv
// Self-checking bench for vga_scene_render: directed scenarios plus a
// randomized run compared against a frame-level reference model.
module tb_vga_scene_render;

  localparam int          OBJ_W  = 32;
  localparam int          OBJ_H  = 32;
  localparam logic [11:0] BG     = 12'h024;
  localparam logic [11:0] OBJ    = 12'hF00;
  localparam logic [11:0] BORDER = 12'hFFF;

  logic        clk_50m = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [10:0] xpos = '0, ypos = '0, pos_x = '0, pos_y = '0;
  logic        hsync_in = 1'b1, vsync_in = 1'b1, pos_wr = 1'b0;
  logic        pos_busy, hsync, vsync;
  logic [11:0] rgb;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          act_mx, act_my, sh_mx, sh_my, cnt_m;
  bit          pend_m, prev_vs_m;
  logic [13:0] exp_q[$];

  vga_scene_render #(
    .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .BG_COLOR(BG), .OBJ_COLOR(OBJ), .BORDER_COLOR(BORDER)
  ) dut (
    .clk_50m(clk_50m), .rst(rst), .valid(valid), .xpos(xpos), .ypos(ypos),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pos_x(pos_x), .pos_y(pos_y),
    .pos_wr(pos_wr), .pos_busy(pos_busy), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .frame_cnt(frame_cnt)
  );

  always #5 clk_50m = ~clk_50m;

  // Expected colour of one pixel given the object position in effect.
  function automatic logic [11:0] ref_color(logic v, int x, int y);
    if (!v) return 12'h000;
    if (x == 0 || x == 799 || y == 0 || y == 599) return BORDER;
    if (x >= act_mx && x < act_mx + OBJ_W && y >= act_my && y < act_my + OBJ_H) return OBJ;
    return BG;
  endfunction

  task automatic model_reset();
    act_mx = 0; act_my = 0; sh_mx = 0; sh_my = 0; cnt_m = 0;
    pend_m = 0; prev_vs_m = 1;
    exp_q.delete();
    exp_q.push_back({12'h000, 1'b1, 1'b1});
  endtask

  task automatic set_idle();
    valid = 0; hsync_in = 1; vsync_in = 1; pos_wr = 0;
  endtask

  // One clock: record expected output for current inputs, advance model;
  // e returns what the DUT should show now (inputs of the previous cycle).
  task automatic tick(output logic [13:0] e);
    bit bnd;
    exp_q.push_back({ref_color(valid, int'(xpos), int'(ypos)), hsync_in, vsync_in});
    bnd = prev_vs_m && !vsync_in;
    @(posedge clk_50m); #1;
    if (pend_m && bnd) begin
      act_mx = sh_mx; act_my = sh_my; pend_m = 0;
    end else if (!pend_m && pos_wr) begin
      sh_mx = (int'(pos_x) > 800 - OBJ_W) ? 800 - OBJ_W : int'(pos_x);
      sh_my = (int'(pos_y) > 600 - OBJ_H) ? 600 - OBJ_H : int'(pos_y);
      pend_m = 1;
    end
    if (bnd) cnt_m = (cnt_m + 1) & 16'hFFFF;
    prev_vs_m = vsync_in;
    e = exp_q.pop_front();
  endtask

  // Drive one visible pixel and return the colour it produced two cycles later.
  task automatic probe(input int x, input int y, output logic [11:0] got);
    logic [13:0] e;
    valid = 1; xpos = 11'(x); ypos = 11'(y);
    tick(e);
    valid = 0;
    tick(e);
    got = rgb;
    $display("probe (%0d,%0d) rgb=%h", x, y, got);
  endtask

  task automatic boundary_pulse();
    logic [13:0] e;
    vsync_in = 0; tick(e);
    vsync_in = 1; tick(e);
  endtask

  task automatic do_reset();
    rst = 1; set_idle();
    repeat (2) @(posedge clk_50m);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    set_idle();
    #1 rst = 1;
    #1;
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", rgb); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL reset_sync got %b%b want 11", hsync, vsync); end
    checks++; if (pos_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", pos_busy); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", frame_cnt); end
    @(posedge clk_50m); #1 rst = 0;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_latency();
    logic [13:0] e;
    set_idle(); tick(e); tick(e);
    valid = 1; xpos = 11'd400; ypos = 11'd300;
    tick(e); valid = 0;
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL lat_rgb_1cyc got %h want 000", rgb); end
    tick(e);
    checks++; if (rgb !== BG) begin errors++; $display("FAIL lat_rgb_2cyc got %h want %h", rgb, BG); end
    hsync_in = 0; tick(e); hsync_in = 1;
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL lat_hs_1cyc got %b want 1", hsync); end
    tick(e);
    checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL lat_hs_2cyc got %b want 0", hsync); end
    tick(e);
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL lat_hs_3cyc got %b want 1", hsync); end
    vsync_in = 0; tick(e); vsync_in = 1;
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL lat_vs_1cyc got %b want 1", vsync); end
    tick(e);
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL lat_vs_2cyc got %b want 0", vsync); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL lat_cnt got %0d want 1", frame_cnt); end
    $display("test_latency done");
  endtask

  task automatic test_border();
    logic [11:0] got;
    logic [13:0] e;
    set_idle();
    probe(0, 10, got);    checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL border_x0 got %h want FFF", got); end
    probe(799, 10, got);  checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL border_x799 got %h want FFF", got); end
    probe(400, 0, got);   checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL border_y0 got %h want FFF", got); end
    probe(400, 599, got); checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL border_y599 got %h want FFF", got); end
    probe(1, 10, got);    checks++; if (got !== OBJ) begin errors++; $display("FAIL obj_at_origin got %h want %h", got, OBJ); end
    probe(32, 10, got);   checks++; if (got !== BG) begin errors++; $display("FAIL obj_right_edge got %h want %h", got, BG); end
    valid = 0; xpos = 11'd0; ypos = 11'd10; tick(e); tick(e);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank got %h want 000", rgb); end
    $display("test_border done");
  endtask

  task automatic test_deferred();
    logic [11:0] got;
    logic [13:0] e;
    set_idle();
    pos_x = 11'd100; pos_y = 11'd50; pos_wr = 1; tick(e); pos_wr = 0;
    checks++; if (pos_busy !== 1'b1) begin errors++; $display("FAIL defer_busy got %b want 1", pos_busy); end
    probe(100, 50, got); checks++; if (got !== BG) begin errors++; $display("FAIL defer_old_new got %h want %h", got, BG); end
    probe(10, 10, got);  checks++; if (got !== OBJ) begin errors++; $display("FAIL defer_old_obj got %h want %h", got, OBJ); end
    boundary_pulse();
    probe(100, 50, got); checks++; if (got !== OBJ) begin errors++; $display("FAIL defer_new_obj got %h want %h", got, OBJ); end
    probe(132, 50, got); checks++; if (got !== BG) begin errors++; $display("FAIL defer_new_right got %h want %h", got, BG); end
    probe(131, 81, got); checks++; if (got !== OBJ) begin errors++; $display("FAIL defer_new_corner got %h want %h", got, OBJ); end
    probe(10, 10, got);  checks++; if (got !== BG) begin errors++; $display("FAIL defer_old_gone got %h want %h", got, BG); end
    checks++; if (pos_busy !== 1'b0) begin errors++; $display("FAIL defer_idle got %b want 0", pos_busy); end
    $display("test_deferred done");
  endtask

  task automatic test_back_to_back();
    logic [11:0] got;
    logic [13:0] e;
    set_idle();
    pos_x = 11'd300; pos_y = 11'd100; pos_wr = 1; tick(e); pos_wr = 0;
    pos_x = 11'd200; pos_y = 11'd200; pos_wr = 1; tick(e); pos_wr = 0;
    boundary_pulse();
    probe(300, 100, got); checks++; if (got !== OBJ) begin errors++; $display("FAIL busy_first_kept got %h want %h", got, OBJ); end
    probe(200, 200, got); checks++; if (got !== BG) begin errors++; $display("FAIL busy_second_ignored got %h want %h", got, BG); end
    // request coincides with the boundary cycle
    pos_x = 11'd400; pos_y = 11'd400; pos_wr = 1; vsync_in = 0; tick(e);
    pos_wr = 0; vsync_in = 1; tick(e);
    checks++; if (pos_busy !== 1'b1) begin errors++; $display("FAIL simul_busy got %b want 1", pos_busy); end
    probe(400, 400, got); checks++; if (got !== BG) begin errors++; $display("FAIL simul_not_yet got %h want %h", got, BG); end
    probe(300, 100, got); checks++; if (got !== OBJ) begin errors++; $display("FAIL simul_old got %h want %h", got, OBJ); end
    boundary_pulse();
    probe(400, 400, got); checks++; if (got !== OBJ) begin errors++; $display("FAIL simul_applied got %h want %h", got, OBJ); end
    checks++; if (pos_busy !== 1'b0) begin errors++; $display("FAIL simul_idle got %b want 0", pos_busy); end
    $display("test_back_to_back done");
  endtask

  task automatic test_clamp();
    logic [11:0] got;
    logic [13:0] e;
    set_idle();
    pos_x = 11'd790; pos_y = 11'd590; pos_wr = 1; tick(e); pos_wr = 0;
    boundary_pulse();
    probe(768, 568, got); checks++; if (got !== OBJ) begin errors++; $display("FAIL clamp_corner got %h want %h", got, OBJ); end
    probe(767, 568, got); checks++; if (got !== BG) begin errors++; $display("FAIL clamp_left got %h want %h", got, BG); end
    probe(768, 567, got); checks++; if (got !== BG) begin errors++; $display("FAIL clamp_top got %h want %h", got, BG); end
    probe(798, 598, got); checks++; if (got !== OBJ) begin errors++; $display("FAIL clamp_far got %h want %h", got, OBJ); end
    $display("test_clamp done");
  endtask

  task automatic test_random();
    logic [13:0] e;
    int x, y, bad;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      valid    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        x = act_mx + $urandom_range(0, OBJ_W + 8) - 4;
        y = act_my + $urandom_range(0, OBJ_H + 8) - 4;
        x = (x < 0) ? 0 : (x > 799) ? 799 : x;
        y = (y < 0) ? 0 : (y > 599) ? 599 : y;
      end else begin
        x = $urandom_range(0, 799);
        y = $urandom_range(0, 599);
      end
      xpos     = 11'(x);
      ypos     = 11'(y);
      hsync_in = ($urandom_range(0, 7) != 0);
      vsync_in = ($urandom_range(0, 15) != 0);
      pos_wr   = ($urandom_range(0, 11) == 0);
      pos_x    = 11'($urandom_range(0, 2047));
      pos_y    = 11'($urandom_range(0, 2047));
      tick(e);
      checks++;
      if ({rgb, hsync, vsync} !== e) begin
        errors++; bad++;
        $display("FAIL rand_pixel cyc %0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                 i, rgb, hsync, vsync, e[13:2], e[1], e[0]);
      end
      checks++;
      if (pos_busy !== pend_m) begin
        errors++; bad++; $display("FAIL rand_busy cyc %0d got %b want %b", i, pos_busy, pend_m);
      end
      checks++;
      if (frame_cnt !== 16'(cnt_m)) begin
        errors++; bad++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", i, frame_cnt, cnt_m);
      end
    end
    set_idle();
    $display("test_random done, %0d mismatching cycles", bad);
  endtask

  task automatic test_count();
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      vsync_in = 0; @(posedge clk_50m); #1;
      vsync_in = 1; @(posedge clk_50m); #1;
      if (i == 65534) begin
        checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_max got %h want FFFF", frame_cnt); end
      end
    end
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got %h want 0000", frame_cnt); end
    do_reset();
    $display("test_count done");
  endtask

  task automatic test_reset_pending();
    logic [11:0] got;
    logic [13:0] e;
    set_idle();
    boundary_pulse();
    pos_x = 11'd500; pos_y = 11'd500; pos_wr = 1; tick(e); pos_wr = 0;
    checks++; if (pos_busy !== 1'b1) begin errors++; $display("FAIL rstp_busy_before got %b want 1", pos_busy); end
    #2 rst = 1;
    #1;
    checks++; if (pos_busy !== 1'b0) begin errors++; $display("FAIL rstp_busy got %b want 0", pos_busy); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL rstp_cnt got %h want 0", frame_cnt); end
    @(posedge clk_50m); #1 rst = 0;
    model_reset();
    probe(10, 10, got);   checks++; if (got !== OBJ) begin errors++; $display("FAIL rstp_origin got %h want %h", got, OBJ); end
    probe(500, 500, got); checks++; if (got !== BG) begin errors++; $display("FAIL rstp_discard got %h want %h", got, BG); end
    boundary_pulse();
    probe(500, 500, got); checks++; if (got !== BG) begin errors++; $display("FAIL rstp_discard_frame got %h want %h", got, BG); end
    checks++; if (pos_busy !== 1'b0) begin errors++; $display("FAIL rstp_idle got %b want 0", pos_busy); end
    $display("test_reset_pending done");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_border();
    test_deferred();
    test_back_to_back();
    test_clamp();
    test_random();
    test_count();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
